// File: rtl/stopwatch_ones_digit.sv
// -----------------------------------------------------------------------------
// stopwatch_ones_digit
//   Least-significant stopwatch stage. A prescaler divides clk into a one-cycle
//   tick; a run-control FSM (IDLE / RUN / PAUSED) gates the prescaler; a
//   reversible BCD-style digit counts up or down on each tick. 'carry' is the
//   enable for the next (tens) stage and is valid in the tick cycle, so both
//   stages update on the same clk edge.
//
//   Optional feature: define AUTO_STOP_EN to add a DONE state that halts a
//   countdown when this digit and all higher digits reach zero.
//
// Parameters
//   DIV        clk cycles per tick (>= 2)
//   MAX_DIGIT  terminal digit value (1..15)
//
// Ports
//   clk        clock, all state on rising edge
//   reset      synchronous active-high reset, highest priority
//   start      level: IDLE/PAUSED -> RUN
//   stop       level: RUN -> PAUSED (wins over start)
//   clear      level: any state -> IDLE, digit and prescaler zeroed
//   reverse    0 = count up, 1 = count down
//   load       digit <= min(load_val, MAX_DIGIT), any state
//   load_val   preset value
//   upper_zero all higher digits are zero (AUTO_STOP_EN only)
//   digit      current ones value
//   tick       one-cycle tick (combinational)
//   carry      enable of next stage (combinational)
//   running    state == RUN
//   done       one-cycle registered pulse on countdown expiry
// -----------------------------------------------------------------------------
module stopwatch_ones_digit #(
  parameter int unsigned DIV       = 50_000_000,
  parameter int unsigned MAX_DIGIT = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       reverse,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       upper_zero,
  output logic [3:0] digit,
  output logic       tick,
  output logic       carry,
  output logic       running,
  output logic       done
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [3:0]    MAX_D      = 4'(MAX_DIGIT);

`ifdef AUTO_STOP_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED} state_t;
`endif

  state_t        state;
  logic [PW-1:0] presc;
  logic          at_terminal;
  logic          expire;
  logic [3:0]    load_clamped;
  logic [3:0]    digit_step;

  // Combinational outputs and next-digit helpers.
  // NOTE: every always_comb output is given a value on every path, so no latch
  // can be inferred.
  always_comb begin
    tick         = (state == S_RUN) && (presc == PRESC_LAST);
    running      = (state == S_RUN);
    at_terminal  = reverse ? (digit == 4'd0) : (digit == MAX_D);
`ifdef AUTO_STOP_EN
    expire       = tick && reverse && (digit == 4'd0) && upper_zero;
`else
    expire       = 1'b0;
`endif
    // On expiry the countdown stops at zero instead of wrapping, so no borrow.
    carry        = tick && at_terminal && !expire;
    load_clamped = (load_val > MAX_D) ? MAX_D : load_val;
    if (reverse)
      digit_step = (digit == 4'd0) ? MAX_D : digit - 4'd1;
    else
      digit_step = (digit == MAX_D) ? 4'd0 : digit + 4'd1;
  end

`ifndef AUTO_STOP_EN
  // upper_zero only matters for the auto-stop feature.
  logic unused_upper_zero;
  assign unused_upper_zero = upper_zero;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state <= S_IDLE;
      presc <= '0;
      digit <= 4'd0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;

      // Prescaler: free-runs in RUN, keeps the fraction while PAUSED.
      case (state)
        S_RUN:    presc <= tick ? '0 : presc + 1'b1;
        S_PAUSED: presc <= presc;
        default:  presc <= '0;
      endcase

      // Load beats a count in the same cycle.
      if (load)
        digit <= load_clamped;
      else if (tick && !expire)
        digit <= digit_step;

      // Run control: stop wins over start; expiry wins over both.
      case (state)
`ifdef AUTO_STOP_EN
        S_DONE: begin
          if (load) state <= S_IDLE;
        end
`endif
        S_RUN: begin
          if (expire && !load) begin
`ifdef AUTO_STOP_EN
            state <= S_DONE;
`endif
            done  <= 1'b1;
          end else if (stop) begin
            state <= S_PAUSED;
          end
        end
        default: begin
          if (!stop && start) state <= S_RUN;
        end
      endcase
    end
  end

endmodule
